// File: rtl/issue_sb.sv
// N-lane in-order issue stage: register file with write-through bypass, per-register scoreboard,
// intra-bundle hazard checks with partial-bundle issue, and a registered output toward execute.
module issue_sb #(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                            clock_i,
  input  logic                            reset_n_i,
  input  logic                            flush_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [LANES*32-1:0]             in_inst_i,
  input  logic [LANES-1:0]                in_lane_valid_i,
  input  logic [LANES-1:0]                in_rd_we_i,
  input  logic [LANES*$clog2(NREGS)-1:0]  wb_addr_i,
  input  logic [LANES*XLEN-1:0]           wb_data_i,
  input  logic [LANES-1:0]                wb_write_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [LANES-1:0]                out_lane_valid_o,
  output logic [LANES*32-1:0]             out_inst_o,
  output logic [LANES*XLEN-1:0]           out_rs1_data_o,
  output logic [LANES*XLEN-1:0]           out_rs2_data_o,
  output logic [NREGS-1:0]                busy_o
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]       rf_q [NREGS];
  logic [NREGS-1:0]      busy_q, busy_d, busy_free, busy_set, wb_clr;
  logic [LANES-1:0]      pending_q, pending_d, eff_pending, issued;
  logic                  out_valid_q, out_free;
  logic [LANES-1:0]      out_lane_valid_q;
  logic [LANES*32-1:0]   out_inst_q;
  logic [LANES*XLEN-1:0] out_rs1_q, out_rs2_q, rs1_flat, rs2_flat;
  logic [AW-1:0]         rs1 [LANES];
  logic [AW-1:0]         rs2 [LANES];
  logic [AW-1:0]         rd  [LANES];

  assign out_free    = !out_valid_q || out_ready_i;
  assign eff_pending = (pending_q != '0) ? pending_q : in_lane_valid_i;

  // Register read with bypass; ascending port order lets the highest lane win.
  always_comb begin : read_ports
    wb_clr   = '0;
    rs1_flat = '0;
    rs2_flat = '0;
    for (int w = 0; w < LANES; w++) begin
      if (wb_write_i[w] && wb_addr_i[w*AW +: AW] != '0) wb_clr[wb_addr_i[w*AW +: AW]] = 1'b1;
    end
    for (int k = 0; k < LANES; k++) begin
      rs1[k] = in_inst_i[32*k+15 +: AW];
      rs2[k] = in_inst_i[32*k+20 +: AW];
      rd[k]  = in_inst_i[32*k+7 +: AW];
      rs1_flat[k*XLEN +: XLEN] = rf_q[rs1[k]];
      rs2_flat[k*XLEN +: XLEN] = rf_q[rs2[k]];
      for (int w = 0; w < LANES; w++) begin
        if (wb_write_i[w] && wb_addr_i[w*AW +: AW] != '0) begin
          if (wb_addr_i[w*AW +: AW] == rs1[k]) rs1_flat[k*XLEN +: XLEN] = wb_data_i[w*XLEN +: XLEN];
          if (wb_addr_i[w*AW +: AW] == rs2[k]) rs2_flat[k*XLEN +: XLEN] = wb_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  assign busy_free = busy_q & ~wb_clr;

  always_comb begin : issue_logic
    logic ok_prev;
    logic hazard;
    issued   = '0;
    busy_set = '0;
    ok_prev  = in_valid_i && out_free && !flush_i;
    for (int k = 0; k < LANES; k++) begin
      hazard = busy_free[rs1[k]] || busy_free[rs2[k]] || (in_rd_we_i[k] && busy_free[rd[k]]);
      for (int j = 0; j < k; j++) begin
        if (eff_pending[j] && in_rd_we_i[j] && rd[j] != '0 &&
            (rd[j] == rs1[k] || rd[j] == rs2[k] || (in_rd_we_i[k] && rd[j] == rd[k]))) begin
          hazard = 1'b1;
        end
      end
      issued[k] = eff_pending[k] && ok_prev && !hazard;
      if (eff_pending[k] && !issued[k]) ok_prev = 1'b0;
      if (issued[k] && in_rd_we_i[k] && rd[k] != '0) busy_set[rd[k]] = 1'b1;
    end
  end

  assign in_ready_o = in_valid_i && ((eff_pending & ~issued) == '0);

  always_comb begin : next_state
    busy_d    = flush_i ? '0 : ((busy_q & ~wb_clr) | busy_set);
    busy_d[0] = 1'b0;
    pending_d = pending_q;
    if (flush_i)         pending_d = '0;
    else if (in_valid_i) pending_d = in_ready_o ? '0 : (eff_pending & ~issued);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q           <= '0;
      pending_q        <= '0;
      out_valid_q      <= 1'b0;
      out_lane_valid_q <= '0;
      out_inst_q       <= '0;
      out_rs1_q        <= '0;
      out_rs2_q        <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      if (flush_i) begin
        out_valid_q      <= 1'b0;
        out_lane_valid_q <= '0;
      end else if (out_free) begin
        out_valid_q      <= |issued;
        out_lane_valid_q <= issued;
        out_inst_q       <= in_inst_i;
        out_rs1_q        <= rs1_flat;
        out_rs2_q        <= rs2_flat;
      end
    end
  end

  // Writebacks land even during flush; x0 is never written so it always reads zero.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else begin
      for (int w = 0; w < LANES; w++) begin
        if (wb_write_i[w] && wb_addr_i[w*AW +: AW] != '0) begin
          rf_q[wb_addr_i[w*AW +: AW]] <= wb_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_lane_valid_o = out_lane_valid_q;
  assign out_inst_o       = out_inst_q;
  assign out_rs1_data_o   = out_rs1_q;
  assign out_rs2_data_o   = out_rs2_q;
  assign busy_o           = busy_q;

endmodule

// File: doc/issue_sb.md
Name: issue_sb

Overview:
- Parametrised N-lane in-order issue stage; successor to the fixed dual-issue register-read stage.
- Integrates a multi-port register file with write-through bypass and a per-register scoreboard.
- Performs intra-bundle dependency checks and partial-bundle issue, and registers issued operands toward execute under a valid/ready handshake.
- Sits between decode (bundle source) and the execute lanes (writeback sources).

Parameters:
- LANES, 2, number of issue lanes and writeback ports.
- XLEN, 32, register data width.
- NREGS, 32, architectural register count; the address width is log2(NREGS), 5 by default.

Ports:
- clock_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  drop held bundle, output register and all busy bits.
- in_valid_i  in  1  bundle valid.
- in_ready_o  out  1  bundle fully issued this cycle (combinational).
- in_inst_i  in  LANES*32  lane k at [32k+31:32k]; rs1=[19:15], rs2=[24:20], rd=[11:7].
- in_lane_valid_i  in  LANES  lanes that hold a real instruction.
- in_rd_we_i  in  LANES  lane writes rd.
- wb_addr_i  in  LANES*5  writeback addresses.
- wb_data_i  in  LANES*XLEN  writeback data.
- wb_write_i  in  LANES  writeback enables.
- out_valid_o  out  1  output register valid.
- out_ready_i  in  1  execute accepts.
- out_lane_valid_o  out  LANES  lanes issued in the output bundle.
- out_inst_o  out  LANES*32  issued instructions.
- out_rs1_data_o  out  LANES*XLEN  operand 1 per lane.
- out_rs2_data_o  out  LANES*XLEN  operand 2 per lane.
- busy_o  out  NREGS  scoreboard bits (debug and verification).

Behaviour:

Reset (reset_n_i low, asynchronous):
- busy=0, pending_r=0.
- out_valid_o=0; out_lane_valid_o, out_inst_o and operand outputs all 0.
- Register file cleared to 0.

Register file:
- x0 reads 0 and ignores writes.
- Writes take effect on the clock edge.
- Same-cycle reads bypass matching wb data. If two wb ports hit the same address, the higher lane index wins, for both the bypass and the stored value.

Pending lanes:
- eff_pending = (pending_r != 0) ? pending_r : in_lane_valid_i.
- The bundle must stay stable while in_valid_i is high and in_ready_o is low.

Issue condition for lane k (all must hold):
- in_valid_i and eff_pending[k].
- Output free: !out_valid_o or out_ready_i.
- Every lower pending lane also issues (strict in-order).
- rs1, rs2 and, if in_rd_we_i[k], rd are not busy. A busy register that is cleared by a wb in the same cycle counts as free.
- No lower pending lane j with in_rd_we_i[j] and rd_j != 0 has rd_j equal to rs1_k, rs2_k or (if written) rd_k. This covers RAW and WAW within the bundle.

Sequencing:
- in_ready_o = in_valid_i and every eff_pending lane issues. An all-zero lane mask is accepted immediately with no output.
- On partial issue, pending_r <= eff_pending & ~issued. On full issue, pending_r <= 0.
- Output register loads when free: out_valid_o <= |issued, along with the issued mask, instructions and operands. Latency from issue to out_valid_o is 1 cycle.
- While out_valid_o and !out_ready_i, all outputs hold.

Scoreboard:
- Issue of a lane with in_rd_we_i and rd != 0 sets busy[rd].
- wb_write_i with addr != 0 clears busy[addr].
- Simultaneous set and clear on the same register: set wins.
- busy[0] is always 0.

Flush:
- flush_i has priority over issue. Next cycle: pending_r=0, out_valid_o=0, busy=0.
- Writebacks in the flush cycle still update the register file.
- No issue occurs in the flush cycle.

Test Plan:
1. Reset, then 2-lane bundle lane0 "addi x1,x0,5", lane1 "add x3,x4,x5" with regs zero -> in_ready_o=1 same cycle; next cycle out_valid_o=1, out_lane_valid_o=2'b11, busy_o[1]=busy_o[3]=1.
2. Intra-bundle RAW: lane0 writes x6, lane1 reads x6 -> cycle 1: lane0 only issues, in_ready_o=0, pending_r=2'b10. Lane1 stalls until wb x6=0x1234; in that wb cycle it issues with out_rs1_data=0x1234 (bypass) and in_ready_o=1.
3. Dual wb to x7 (lane0=0xA, lane1=0xB) and a concurrent read of x7 -> operand 0xB; later read of x7 = 0xB.
4. Backpressure: out_ready_i=0 for 3 cycles with out_valid_o=1 -> outputs stable, in_ready_o=0, no busy change; release -> next bundle appears 1 cycle later.
5. Same-cycle issue (sets x9) and wb clearing x9 -> busy_o[9]=1 afterwards; writes to x0 -> x0 reads 0, busy_o[0]=0.
6. flush_i during partial issue with out_valid_o=1 -> next cycle out_valid_o=0, busy_o=0, pending_r=0. Assert reset_n_i mid-stall -> all outputs 0 asynchronously.
